// File: rtl/r5p_gpio_ctl.sv
// r5p_gpio_ctl: memory-mapped GPIO controller, TCB slave, single-cycle accept.
//   Holds OUT/ENA, exposes the synchronized input vector, and (when the
//   R5P_GPIO_IRQ_EN macro is defined) detects rising/falling input edges
//   into a W1C pending register that drives a level interrupt.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   tcb_*             bus request (vld/wen/adr/ben/wdt), rdy tied 1,
//                     rdt registered, valid one cycle after an accepted read
//   gpio_o / gpio_e   output values / output enables to pads
//   gpio_i            pad inputs, already synchronized to clk
//   irq               level interrupt, registered (0 without R5P_GPIO_IRQ_EN)
// Register slots (tcb_adr[4:2]): 0 OUT, 1 ENA, 2 IN, 3 RISE, 4 FALL,
//   5 PEND (W1C), 6 SET (OUT |= wdt), 7 CLR (OUT &= ~wdt).
module r5p_gpio_ctl #(
  parameter int GW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tcb_vld,
  output logic          tcb_rdy,
  input  logic          tcb_wen,
  input  logic [AW-1:0] tcb_adr,
  input  logic [3:0]    tcb_ben,
  input  logic [31:0]   tcb_wdt,
  output logic [31:0]   tcb_rdt,
  output logic [GW-1:0] gpio_o,
  output logic [GW-1:0] gpio_e,
  input  logic [GW-1:0] gpio_i,
  output logic          irq
);

  localparam logic [2:0] S_OUT  = 3'd0;
  localparam logic [2:0] S_ENA  = 3'd1;
  localparam logic [2:0] S_IN   = 3'd2;
  localparam logic [2:0] S_RISE = 3'd3;
  localparam logic [2:0] S_FALL = 3'd4;
  localparam logic [2:0] S_PEND = 3'd5;

  logic [2:0]    w_slot;
  logic          w_we, w_re;
  logic [31:0]   w_bmask;
  logic [GW-1:0] w_m, w_wd;
  logic [31:0]   w_rd;
  logic          w_unused;

  logic [GW-1:0] r_out, r_ena;
  logic [31:0]   r_rdt;

  assign tcb_rdy = 1'b1;
  assign w_slot  = tcb_adr[4:2];
  assign w_we    = tcb_vld &  tcb_wen;
  assign w_re    = tcb_vld & ~tcb_wen;
  assign w_bmask = {{8{tcb_ben[3]}}, {8{tcb_ben[2]}}, {8{tcb_ben[1]}}, {8{tcb_ben[0]}}};
  // Bits at or above GW are simply never stored.
  assign w_m     = w_bmask[GW-1:0];
  assign w_wd    = tcb_wdt[GW-1:0];
  assign w_unused = ^{tcb_adr, tcb_wdt, w_bmask};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      r_ena <= '0;
    end else if (w_we) begin
      case (w_slot)
        S_OUT:   r_out <= (r_out & ~w_m) | (w_wd & w_m);
        S_ENA:   r_ena <= (r_ena & ~w_m) | (w_wd & w_m);
        3'd6:    r_out <= r_out | (w_wd & w_m);
        3'd7:    r_out <= r_out & ~(w_wd & w_m);
        default: ;
      endcase
    end
  end

  assign gpio_o = r_out;
  assign gpio_e = r_ena;

`ifdef R5P_GPIO_IRQ_EN
  logic [GW-1:0] r_gpio_q, r_rise, r_fall, r_pend;
  logic          r_irq;
  logic [GW-1:0] w_evt, w_pclr, w_pend_nxt;

  assign w_evt      = (gpio_i & ~r_gpio_q & r_rise) | (~gpio_i & r_gpio_q & r_fall);
  assign w_pclr     = (w_we && w_slot == S_PEND) ? (w_wd & w_m) : '0;
  // Clear first, then OR in new events: a same-cycle event wins over W1C.
  assign w_pend_nxt = (r_pend & ~w_pclr) | w_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gpio_q <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_pend   <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_gpio_q <= gpio_i;
      r_pend   <= w_pend_nxt;
      r_irq    <= |w_pend_nxt;
      if (w_we && w_slot == S_RISE) r_rise <= (r_rise & ~w_m) | (w_wd & w_m);
      if (w_we && w_slot == S_FALL) r_fall <= (r_fall & ~w_m) | (w_wd & w_m);
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    w_rd = '0;
    case (w_slot)
      S_OUT:  w_rd[GW-1:0] = r_out;
      S_ENA:  w_rd[GW-1:0] = r_ena;
      S_IN:   w_rd[GW-1:0] = gpio_i;
`ifdef R5P_GPIO_IRQ_EN
      S_RISE: w_rd[GW-1:0] = r_rise;
      S_FALL: w_rd[GW-1:0] = r_fall;
      S_PEND: w_rd[GW-1:0] = r_pend;
`endif
      default: w_rd = '0;
    endcase
  end

  // Read data holds until the next accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdt <= '0;
    else if (w_re) r_rdt <= w_rd;
  end

  assign tcb_rdt = r_rdt;

endmodule

// File: doc/r5p_gpio_ctl.md
# r5p_gpio_ctl

Memory-mapped GPIO controller inside the R5P SoC: the bus-side end of the `gpio_o`/`gpio_e`/`gpio_i` pin interface that the board top-level turns into tristate pads and input synchronizers. It holds the output and output-enable registers, exposes the already-synchronized input vector, and detects rising and falling input edges into a write-1-to-clear pending register that drives a level interrupt. It is a single-cycle-accept TCB slave with registered read data.

## Interface
- `GW`, 32: GPIO width; 1..32.
- `AW`, 5: byte-address width of the register window; 32 B, 8 word slots.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `tcb_vld`  in  1  request valid.
- `tcb_rdy`  out  1  request ready; tied 1.
- `tcb_wen`  in  1  1 = write, 0 = read.
- `tcb_adr`  in  AW  byte address; bits [1:0] ignored.
- `tcb_ben`  in  4  write byte enables.
- `tcb_wdt`  in  32  write data.
- `tcb_rdt`  out  32  read data, valid 1 cycle after accepted read.
- `gpio_o`  out  GW  output values to pads.
- `gpio_e`  out  GW  output enables; 1 = drive.
- `gpio_i`  in  GW  pad inputs, already synchronized to `clk`.
- `irq`  out  1  level interrupt.

## Operation
- Register map (`tcb_adr[4:2]`):
  - 0 OUT: rw, drives `gpio_o`.
  - 1 ENA: rw, drives `gpio_e`.
  - 2 IN: ro, current `gpio_i`.
  - 3 RISE: rw, rising-edge interrupt enable mask.
  - 4 FALL: rw, falling-edge interrupt enable mask.
  - 5 PEND: read pending bits; write 1 clears (W1C).
  - 6 SET: wo, OUT |= wdt.
  - 7 CLR: wo, OUT &= ~wdt.
- Writes honour `tcb_ben` per byte on all writable slots, SET/CLR included.
- Bits at or above `GW` read 0 and ignore writes.
- Reads of SET/CLR return 0.
- Edge detect: `gpio_q` registers `gpio_i` each cycle.
  - rise = `gpio_i & ~gpio_q`; fall = `~gpio_i & gpio_q`.
  - PEND |= (rise & RISE) | (fall & FALL).
- `irq` = |PEND, driven from registers with no combinational path from the bus.
- Same-cycle PEND W1C clear and new event on one bit: set wins.
- Same-cycle SET/CLR and OUT write cannot occur, since there is one request per cycle.

## Timing
- Reset values (async, while `rst_n`=0):
  - `gpio_o`, `gpio_e`, RISE, FALL, PEND, `tcb_rdt` = 0.
  - `irq` = 0.
  - `gpio_q` = 0.
- Reset mid-operation immediately clears all of the above. A request in flight is dropped.
- First cycle after reset release: `gpio_q` = 0, so an input held high looks like a rising edge. It is ignored because RISE = 0.
- Write accepted at edge N: the new OUT/ENA value appears on `gpio_o`/`gpio_e` after edge N.
- Read accepted at edge N: `tcb_rdt` is valid after edge N and holds until the next accepted read.
- IN read latency: reads the `gpio_i` value sampled at the accepting edge.
- Input edge present between edges N-1 and N: PEND bit set after edge N, `irq` high after edge N.
- PEND W1C at edge N: `irq` falls after edge N if no other bit is pending.
- Back-to-back requests are supported every cycle; `tcb_rdy` is always 1.

## Configuration
- `R5P_GPIO_IRQ_EN` defined: RISE/FALL/PEND registers, `gpio_q`, and `irq` are implemented as above.
- Not defined:
  - slots 3–5 read 0 and ignore writes.
  - `irq` is tied 0.
  - no edge-detect flops are synthesized.
  - OUT/ENA/IN/SET/CLR are unchanged.

## Test plan
- Reset, then read all 8 slots: every read returns 0x0000_0000, `gpio_o`=`gpio_e`=0, `irq`=0.
- Byte-enable writes:
  - write OUT=0xA5A5_A5A5 with ben=4'b0101 → read OUT = 0x00A5_00A5.
  - SET 0x0000_FF00 → OUT = 0x00A5_FFA5.
  - CLR 0x0000_00FF → OUT = 0x00A5_FF00.
- Rising-edge interrupt:
  - RISE=0x1, drive `gpio_i[0]` 0→1 → PEND=0x1 and `irq`=1 one cycle later.
  - FALL=0 and `gpio_i[0]` 1→0 → no change.
  - W1C 0x1 → `irq`=0.
- Simultaneous clear and event: W1C bit 3 in the same cycle that a falling edge on bit 3 arrives with FALL[3]=1 → PEND[3] stays 1, `irq` stays 1.
- `GW`=8: write 0xFFFF_FFFF to OUT and ENA → reads return 0x0000_00FF. Read IN with `gpio_i`=0x5A → 0x0000_005A.
- Assert `rst_n` low during a pending read with `irq`=1 → all outputs 0 asynchronously. With `R5P_GPIO_IRQ_EN` undefined, edges never raise `irq`.
